deser400_gate_stat: RTL and testbench

DESER400_GATE_STAT -- requirements
Module: deser400_gate_stat

---
 rtl/deser400_gate_stat_if.sv | 39 +++
 rtl/deser400_gate_stat.sv | 171 +++++++++++++++++
 tb/tb_deser400_gate_stat.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/deser400_gate_stat_if.sv
// ---------------------------------------------------------------------------
// deser400_gate_stat_if
// Bundles the gate/strobe inputs and the latched-result outputs of the
// deser400 gate statistics block.
//   master : drives sync, gate, evt, err, rd; observes results
//   slave  : the statistics block itself
//   sync       clock enable for every state update
//   gate       measurement window, high = open
//   evt / err  one-cycle event / error strobes
//   rd         readout acknowledge, clears ready and overrun
//   evt_count / err_count / win_len  results of the last completed window
//   ready      new result available
//   overrun    sticky, a window completed while ready was still set
// ---------------------------------------------------------------------------
interface deser400_gate_stat_if #(
    parameter int CNT_WIDTH = 16,
    parameter int LEN_WIDTH = 24
);
    logic                 sync;
    logic                 gate;
    logic                 evt;
    logic                 err;
    logic                 rd;
    logic [CNT_WIDTH-1:0] evt_count;
    logic [CNT_WIDTH-1:0] err_count;
    logic [LEN_WIDTH-1:0] win_len;
    logic                 ready;
    logic                 overrun;

    modport master (
        output sync, gate, evt, err, rd,
        input  evt_count, err_count, win_len, ready, overrun
    );

    modport slave (
        input  sync, gate, evt, err, rd,
        output evt_count, err_count, win_len, ready, overrun
    );
endinterface

// File: rtl/deser400_gate_stat.sv
// ---------------------------------------------------------------------------
// deser400_gate_stat
// Counts TBM header events and deserializer errors inside a gate window and
// latches the totals plus the window length when the gate closes.
//   clk    : 40 MHz system clock
//   reset  : synchronous, active-high; acts regardless of sync
//   bus    : deser400_gate_stat_if.slave (sync/gate/evt/err/rd in,
//            evt_count/err_count/win_len/ready/overrun out)
// A window that is already open when the block leaves reset is discarded:
// the FSM only arms after it has seen the gate low once.
// ---------------------------------------------------------------------------
module deser400_gate_stat #(
    parameter int CNT_WIDTH = 16,
    parameter int LEN_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    deser400_gate_stat_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [LEN_WIDTH-1:0] len_cnt_q, len_cnt_d;
    logic [CNT_WIDTH-1:0] evt_count_q, evt_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [LEN_WIDTH-1:0] win_len_q, win_len_d;
    logic                 ready_q, ready_d;
    logic                 overrun_q, overrun_d;

    logic                 win_start;
    logic                 win_run;
    logic                 win_end;
    logic                 rd_en;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 inc
    );
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end
        return v;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] sat_inc_len(
        input logic [LEN_WIDTH-1:0] v
    );
        if (v != LEN_MAX) begin
            return v + LEN_ONE;
        end
        return v;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.sync) begin
            case (state_q)
                IDLE:    if (!bus.gate) state_d = ARMED;
                ARMED:   if (bus.gate)  state_d = COUNT;
                COUNT:   if (!bus.gate) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: window start, running and end qualifiers
    always_comb begin
        win_start = bus.sync && (state_q == ARMED) && bus.gate;
        win_run   = bus.sync && (state_q == COUNT) && bus.gate;
        win_end   = bus.sync && (state_q == COUNT) && !bus.gate;
        rd_en     = bus.sync && bus.rd;
    end

    // Working counters and result latch
    always_comb begin
        evt_cnt_d   = evt_cnt_q;
        err_cnt_d   = err_cnt_q;
        len_cnt_d   = len_cnt_q;
        evt_count_d = evt_count_q;
        err_count_d = err_count_q;
        win_len_d   = win_len_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;

        // Counters restart on the first open cycle, so that cycle's
        // strobes count and the length starts at one.
        if (win_start) begin
            evt_cnt_d = {{(CNT_WIDTH-1){1'b0}}, bus.evt};
            err_cnt_d = {{(CNT_WIDTH-1){1'b0}}, bus.err};
            len_cnt_d = LEN_ONE;
        end else if (win_run) begin
            evt_cnt_d = sat_inc_cnt(evt_cnt_q, bus.evt);
            err_cnt_d = sat_inc_cnt(err_cnt_q, bus.err);
            len_cnt_d = sat_inc_len(len_cnt_q);
        end

        // Strobes on the closing cycle are outside the window and dropped.
        if (win_end) begin
            evt_count_d = evt_cnt_q;
            err_count_d = err_cnt_q;
            win_len_d   = len_cnt_q;
        end

        // A latch beats a simultaneous rd: ready stays set, overrun clears.
        if (win_end) begin
            ready_d = 1'b1;
        end else if (rd_en) begin
            ready_d = 1'b0;
        end

        if (rd_en) begin
            overrun_d = 1'b0;
        end else if (win_end && ready_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            len_cnt_q   <= '0;
            evt_count_q <= '0;
            err_count_q <= '0;
            win_len_q   <= '0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            evt_cnt_q   <= evt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            len_cnt_q   <= len_cnt_d;
            evt_count_q <= evt_count_d;
            err_count_q <= err_count_d;
            win_len_q   <= win_len_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        bus.evt_count = evt_count_q;
        bus.err_count = err_count_q;
        bus.win_len   = win_len_q;
        bus.ready     = ready_q;
        bus.overrun   = overrun_q;
    end

endmodule

// File: tb/tb_deser400_gate_stat.sv
// ---------------------------------------------------------------------------
// tb_deser400_gate_stat
// Directed bench for deser400_gate_stat. A 16-bit instance is the main
// target; a 4-bit-counter instance shares every stimulus and is checked for
// saturation. Expected window results are queued when the gate is dropped
// and popped when the DUT presents its result.
// ---------------------------------------------------------------------------
module tb_deser400_gate_stat;

    typedef struct {
        logic [15:0] e;
        logic [15:0] r;
        logic [23:0] l;
        logic        rdy;
        logic        ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    deser400_gate_stat_if #(.CNT_WIDTH(16), .LEN_WIDTH(24)) bus ();
    deser400_gate_stat_if #(.CNT_WIDTH(4),  .LEN_WIDTH(24)) bus4 ();

    assign bus4.sync = bus.sync;
    assign bus4.gate = bus.gate;
    assign bus4.evt  = bus.evt;
    assign bus4.err  = bus.err;
    assign bus4.rd   = bus.rd;

    deser400_gate_stat #(.CNT_WIDTH(16), .LEN_WIDTH(24)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    deser400_gate_stat #(.CNT_WIDTH(4), .LEN_WIDTH(24)) dut4 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus4)
    );

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t sb_q[$];
    exp_t m_last;
    logic m_ready;
    logic m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t x);
        check({tag, " evt_count"}, 32'(bus.evt_count), 32'(x.e));
        check({tag, " err_count"}, 32'(bus.err_count), 32'(x.r));
        check({tag, " win_len"},   32'(bus.win_len),   32'(x.l));
        check({tag, " ready"},     32'(bus.ready),     32'(x.rdy));
        check({tag, " overrun"},   32'(bus.overrun),   32'(x.ovr));
    endtask

    task automatic sb_check(input string tag);
        exp_t x;
        n_cmp++;
        assert (sb_q.size() != 0) else begin
            n_mis++;
            $error("FAIL %s: observed no queued entry expected one", tag);
        end
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            check_outputs(tag, x);
        end
    endtask

    // Drive one clock's worth of inputs, sample on the following falling edge.
    task automatic cyc(input logic s, input logic g, input logic e, input logic r, input logic d);
        bus.sync = s;
        bus.gate = g;
        bus.evt  = e;
        bus.err  = r;
        bus.rd   = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic latch_model(input logic rd_now, input int ne, input int nerr, input int len);
        exp_t x;
        m_ovr   = rd_now ? 1'b0 : (m_ovr | m_ready);
        m_ready = 1'b1;
        x.e   = 16'(ne);
        x.r   = 16'(nerr);
        x.l   = 24'(len);
        x.rdy = m_ready;
        x.ovr = m_ovr;
        m_last = x;
        sb_q.push_back(x);
    endtask

    // Window: evt on the first ne open cycles, err on the last nerr; the
    // closing cycle carries evt=err=1, which must not be counted.
    task automatic window(input int len, input int ne, input int nerr, input logic rd_fall, input string tag);
        for (int i = 0; i < len; i++) begin
            cyc(1'b1, 1'b1, (i < ne), (i >= len - nerr), 1'b0);
        end
        latch_model(rd_fall, ne, nerr, len);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, rd_fall);
        sb_check(tag);
    endtask

    task automatic do_rd(input string tag);
        exp_t x;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        x = m_last;
        x.rdy = 1'b0;
        x.ovr = 1'b0;
        check_outputs(tag, x);
    endtask

    initial begin
        exp_t z;
        z.e = '0; z.r = '0; z.l = '0; z.rdy = 1'b0; z.ovr = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_last  = z;

        // Reset with sync low must still clear everything.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outputs("reset", z);

        // 100-cycle window, 7 events, 2 errors.
        window(100, 7, 2, 1'b0, "win100");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_outputs("hold", m_last);
        do_rd("rd1");

        // Two windows without rd: second overwrites and sets overrun.
        window(5, 3, 1, 1'b0, "winA");
        window(8, 2, 0, 1'b0, "winB_ovr");
        do_rd("rd2");

        // Latch while overrun is set, with rd on the latching edge.
        window(3, 1, 1, 1'b0, "winC");
        window(4, 0, 2, 1'b0, "winD_ovr");
        window(6, 2, 3, 1'b1, "winE_rdlatch");
        do_rd("rd3");

        // Reset mid-window, released while gate is still high.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_last  = z;
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outputs("discard", z);
        window(20, 4, 5, 1'b0, "win20");
        do_rd("rd4");

        // Single-cycle gate pulse.
        window(1, 1, 0, 1'b0, "pulse1");
        do_rd("rd5");

        // Saturation on the 4-bit instance; 16-bit instance counts fully.
        window(40, 40, 40, 1'b0, "win40");
        check("sat4 evt_count", 32'(bus4.evt_count), 32'd15);
        check("sat4 err_count", 32'(bus4.err_count), 32'd15);
        check("sat4 win_len",   32'(bus4.win_len),   32'd40);
        do_rd("rd6");

        // sync toggling: 10 enabled open cycles, evt only on disabled ones,
        // err on 3 enabled ones; a gate-low sync=0 cycle must not latch.
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2 == 0), 1'b1, (i % 2 == 1), ((i % 2 == 0) && (i < 6)), 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("frozen ready", 32'(bus.ready), 32'd0);
        latch_model(1'b0, 0, 3, 10);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        sb_check("synctog");

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_mis++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
